// File: rtl/id_queue.sv
// Decode stage: instruction FIFO feeding a registered R/I/J field decoder.
// Optional macro ID_BYPASS_EN: an empty FIFO lets an accepted beat decode straight into the output register.
module id_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [1:0]       out_type,
    output logic [5:0]       out_opcode,
    output logic [5:0]       out_funct,
    output logic [4:0]       reg_s,
    output logic [4:0]       reg_t,
    output logic [4:0]       reg_d,
    output logic [4:0]       shift,
    output logic [31:0]      imm_ext,
    output logic [31:0]      jump_target,
    output logic [PTR_W:0]   level
);

    localparam logic [1:0] INST_TYPE_R       = 2'd0;
    localparam logic [1:0] INST_TYPE_I       = 2'd1;
    localparam logic [1:0] INST_TYPE_J       = 2'd2;
    localparam logic [1:0] INST_TYPE_INVALID = 2'd3;

    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ZERO   = '0;

    typedef struct packed {
        logic [1:0]  typ;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] imm;
        logic [31:0] jt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst, input logic [31:0] pc);
        dec_t        d;
        logic [5:0]  op;
        logic [31:0] pc_plus4;
        d        = '0;
        d.typ    = INST_TYPE_INVALID;
        op       = inst[31:26];
        pc_plus4 = pc + 32'd4;
        if (op == 6'd0) begin
            d.typ    = INST_TYPE_R;
            d.opcode = op;
            d.funct  = inst[5:0];
            d.rs     = inst[25:21];
            d.rt     = inst[20:16];
            d.rd     = inst[15:11];
            d.sh     = inst[10:6];
        end else if ((op == 6'd2) || (op == 6'd3)) begin
            d.typ    = INST_TYPE_J;
            d.opcode = op;
            d.jt     = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (op[5:4] == 2'b01) begin
            // coprocessor/reserved space: everything stays zero so EX can trap on the type
            d.typ    = INST_TYPE_INVALID;
        end else begin
            d.typ    = INST_TYPE_I;
            d.opcode = op;
            d.rs     = inst[25:21];
            d.rt     = inst[20:16];
            case (op)
                6'h0C, 6'h0D, 6'h0E: d.imm = {16'h0000, inst[15:0]};
                6'h0F:               d.imm = {inst[15:0], 16'h0000};
                default:             d.imm = {{16{inst[15]}}, inst[15:0]};
            endcase
        end
        return d;
    endfunction

    logic [31:0]      mem_inst_r [DEPTH];
    logic [31:0]      mem_pc_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic             out_valid_r;
    logic [31:0]      out_pc_r;
    dec_t             dec_r;

    logic             in_ready_s;
    logic             push_s;
    logic             can_load_s;
    logic             load_fifo_s;
    logic             bypass_s;
    logic             write_s;
    logic             load_s;
    logic [31:0]      head_inst_s;
    logic [31:0]      head_pc_s;
    dec_t             dec_s;

    assign in_ready_s = (level_r != FULL_LEVEL);

    // Handshake qualification, bypass selection and decode of the next head entry
    always_comb begin
        push_s      = in_valid & in_ready_s;
        can_load_s  = ~out_valid_r | out_ready;
        load_fifo_s = (level_r != LVL_ZERO) & can_load_s;
`ifdef ID_BYPASS_EN
        bypass_s    = push_s & (level_r == LVL_ZERO) & can_load_s;
`else
        bypass_s    = 1'b0;
`endif
        write_s     = push_s & ~bypass_s;
        load_s      = load_fifo_s | bypass_s;
        if (bypass_s) begin
            head_inst_s = in_inst;
            head_pc_s   = in_pc;
        end else begin
            head_inst_s = mem_inst_r[rd_ptr_r];
            head_pc_s   = mem_pc_r[rd_ptr_r];
        end
        dec_s = decode(head_inst_s, head_pc_s);
    end

    // Buffer storage; stale contents are harmless because pointers gate visibility
    always_ff @(posedge clk) begin
        if (rst_n && !flush && write_s) begin
            mem_inst_r[wr_ptr_r] <= in_inst;
            mem_pc_r[wr_ptr_r]   <= in_pc;
        end
    end

    // Pointers, occupancy and the decoded output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'h0000_0000;
            dec_r       <= '0;
            dec_r.typ   <= INST_TYPE_INVALID;
        end else if (flush) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_fifo_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_r + {{PTR_W{1'b0}}, write_s} - {{PTR_W{1'b0}}, load_fifo_s};
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_pc_r    <= head_pc_s;
                dec_r       <= dec_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_pc      = out_pc_r;
    assign out_type    = dec_r.typ;
    assign out_opcode  = dec_r.opcode;
    assign out_funct   = dec_r.funct;
    assign reg_s       = dec_r.rs;
    assign reg_t       = dec_r.rt;
    assign reg_d       = dec_r.rd;
    assign shift       = dec_r.sh;
    assign imm_ext     = dec_r.imm;
    assign jump_target = dec_r.jt;
    assign level       = level_r;

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: decode vector table plus backpressure, flush, throughput and reset sequences.
module tb_id_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef ID_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam logic [1:0] T_R = 2'd0, T_I = 2'd1, T_J = 2'd2, T_INV = 2'd3;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, imm_ext, jump_target;
    logic [1:0]  out_type;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  reg_s, reg_t, reg_d, shift;
    logic [PTR_W:0] level;

    int checks = 0;
    int errors = 0;

    id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_type(out_type), .out_opcode(out_opcode), .out_funct(out_funct),
        .reg_s(reg_s), .reg_t(reg_t), .reg_d(reg_d), .shift(shift),
        .imm_ext(imm_ext), .jump_target(jump_target), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  typ;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] imm;
        logic [31:0] jt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_type"}, 64'(out_type), 64'(T_INV));
        check({tag, "_fields"}, 64'({out_opcode, out_funct, reg_s, reg_t, reg_d, shift}), 64'd0);
        check({tag, "_pc_imm_jt"}, {out_pc | imm_ext, jump_target}, 64'd0);
    endtask

    // drives one beat until accepted, bounded
    task automatic push_beat(input logic [31:0] inst, input logic [31:0] pc);
        bit done = 1'b0;
        int b = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        while (!done && b < 20) begin
            done = in_ready;
            @(posedge clk); #1;
            b++;
        end
        in_valid = 1'b0;
        check("push_accepted", 64'(done), 64'd1);
    endtask

    initial begin
        int cyc, idx, got, first, last, sent;
        bit seen, rdy;

        //         inst          pc            type   op     fn     rs     rt     rd     sh     imm            jt
        vecs[0] = '{32'h012A4020, 32'h00400000, T_R,   6'h00, 6'h20, 5'd9,  5'd10, 5'd8,  5'd0,  32'h00000000, 32'h00000000};
        vecs[1] = '{32'h3C08ABCD, 32'h00400004, T_I,   6'h0F, 6'h00, 5'd0,  5'd8,  5'd0,  5'd0,  32'hABCD0000, 32'h00000000};
        vecs[2] = '{32'h3508FFFF, 32'h00400008, T_I,   6'h0D, 6'h00, 5'd8,  5'd8,  5'd0,  5'd0,  32'h0000FFFF, 32'h00000000};
        vecs[3] = '{32'h2108FFFF, 32'h0040000C, T_I,   6'h08, 6'h00, 5'd8,  5'd8,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{32'h08100004, 32'h1FFFFFFC, T_J,   6'h02, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 32'h20400010};
        vecs[5] = '{32'h44800000, 32'h00400010, T_INV, 6'h00, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vecs[6] = '{32'h29088000, 32'h00400014, T_I,   6'h0A, 6'h00, 5'd8,  5'd8,  5'd0,  5'd0,  32'hFFFF8000, 32'h00000000};
        vecs[7] = '{32'h31088000, 32'h00400018, T_I,   6'h0C, 6'h00, 5'd8,  5'd8,  5'd0,  5'd0,  32'h00008000, 32'h00000000};
        vecs[8] = '{32'h0C000001, 32'h00400020, T_J,   6'h03, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000004};
        vecs[9] = '{32'h00031140, 32'h00400024, T_R,   6'h00, 6'h00, 5'd0,  5'd3,  5'd2,  5'd5,  32'h00000000, 32'h00000000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // single beats through the decoder, latency measured from the accepting edge
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 6) begin
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LAT));
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(vecs[i].pc));
            check($sformatf("vec%0d_fields", i),
                  64'({out_type, out_opcode, out_funct, reg_s, reg_t, reg_d, shift}),
                  64'({vecs[i].typ, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh}));
            check($sformatf("vec%0d_imm", i), 64'(imm_ext), 64'(vecs[i].imm));
            check($sformatf("vec%0d_jt", i), 64'(jump_target), 64'(vecs[i].jt));
        end
        @(posedge clk); #1;

        // backpressure: DEPTH+1 beats fill output register plus FIFO
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push_beat(32'h20000000 | 32'(i), 32'h1000 + 32'(i * 4));
        check("bp_level_full", 64'(level), 64'(DEPTH));
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_head_pc", 64'(out_pc), 64'h1000);
        in_valid = 1'b1; in_inst = 32'h20000077; in_pc = 32'h2000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_frozen_pc", 64'(out_pc), 64'h1000);
        check("bp_frozen_imm", 64'(imm_ext), 64'h0);
        check("bp_level_hold", 64'(level), 64'(DEPTH));
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < DEPTH + 1 && cyc < 20) begin
            if (out_valid) begin
                check($sformatf("drain%0d_pc", got), 64'(out_pc), 64'h1000 + 64'(got * 4));
                check($sformatf("drain%0d_imm", got), 64'(imm_ext), 64'(got));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_count", 64'(got), 64'(DEPTH + 1));
        check("drain_valid_low", 64'(out_valid), 64'd0);
        check("drain_level_zero", 64'(level), 64'd0);

        // flush with a full FIFO and a live input beat
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push_beat(32'h012A4020, 32'h3000 + 32'(i * 4));
        check("fl_level_full", 64'(level), 64'(DEPTH));
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h012A4020; in_pc = 32'hDEAD0000;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_level", 64'(level), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("fl_nothing_reappears", 64'(seen), 64'd0);

        // sustained stream: one beat per cycle in and out
        got = 0; sent = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                check($sformatf("tp%0d_pc", got), 64'(out_pc), 64'h4000 + 64'(got * 4));
                if (got == 0) first = c;
                last = c;
                got++;
            end
            in_valid = (sent < 6);
            in_inst  = 32'h00000020;
            in_pc    = 32'h4000 + 32'(sent * 4);
            rdy      = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) sent++;
        end
        in_valid = 1'b0;
        check("tp_count", 64'(got), 64'd6);
        check("tp_span", 64'(last - first), 64'd5);

        // COP1 held at the output, then reset mid-stream
        out_ready = 1'b0;
        push_beat(32'h44800000, 32'h5000);
        push_beat(32'h012A4020, 32'h5004);
        cyc = 0;
        while (!out_valid && cyc < 6) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("cop_valid", 64'(out_valid), 64'd1);
        check("cop_type", 64'(out_type), 64'(T_INV));
        check("cop_pc", 64'(out_pc), 64'h5000);
        check("cop_fields", 64'({out_opcode, out_funct, reg_s, reg_t, reg_d, shift}), 64'd0);
        check("cop_imm_jt", {imm_ext, jump_target}, 64'd0);
        rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h2108FFFF; in_pc = 32'h6000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_reset_state("midreset");
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midreset_nothing_reappears", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
